// File: rtl/comms_tx_scheduler_if.sv
// Bundle of the scheduler's client-side and serializer-side signals.
//   req, buf_in            : per-requester frame offers (NREQ bits / NREQ*WIDTH bits)
//   link_ready, link_busy  : serializer status
//   link_start, link_buf   : serializer start strobe and latched frame
//   grant, done, err       : per-requester owner / completion / abort
//   busy, cur_id           : scheduler activity and current owner index
// master drives requests and serializer status; slave is the scheduler.
interface comms_tx_scheduler_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 256
);
    localparam int unsigned IdW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] buf_in;
    logic                  link_ready;
    logic                  link_busy;
    logic                  link_start;
    logic [WIDTH-1:0]      link_buf;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic [NREQ-1:0]       err;
    logic                  busy;
    logic [IdW-1:0]        cur_id;

    modport master (
        output req, buf_in, link_ready, link_busy,
        input  link_start, link_buf, grant, done, err, busy, cur_id
    );

    modport slave (
        input  req, buf_in, link_ready, link_busy,
        output link_start, link_buf, grant, done, err, busy, cur_id
    );
endinterface

// File: rtl/comms_tx_scheduler.sv
// Round-robin scheduler sharing one serial transmit link among NREQ requesters.
// Latches the winner's frame, strobes the serializer, follows its busy rise/fall,
// enforces an inter-frame gap and reports per-requester done/err pulses.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : comms_tx_scheduler_if.slave (requests, frames, serializer handshake, status)
// All outputs are registered.
module comms_tx_scheduler #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned WIDTH   = 256,
    parameter int unsigned GAP     = 16,
    parameter int unsigned TIMEOUT = 4096
) (
    input logic                 clk,
    input logic                 rst,
    comms_tx_scheduler_if.slave bus
);
    localparam int unsigned IdW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
    localparam int unsigned GapW = $clog2(GAP + 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StXfer  = 2'd2,
        StGap   = 2'd3
    } state_e;

    state_e            stateQ, stateD;
    logic [IdW-1:0]    rrPtrQ, rrPtrD;
    logic [TmoW-1:0]   tmoCntQ, tmoCntD;
    logic [GapW-1:0]   gapCntQ, gapCntD;
    logic              linkStartQ, linkStartD;
    logic [WIDTH-1:0]  linkBufQ, linkBufD;
    logic [NREQ-1:0]   grantQ, grantD;
    logic [NREQ-1:0]   doneQ, doneD;
    logic [NREQ-1:0]   errQ, errD;
    logic              busyQ, busyD;
    logic [IdW-1:0]    curIdQ, curIdD;

    logic              pickValid;
    logic [IdW-1:0]    pickId;
    logic [NREQ-1:0]   pickOneHot;
    logic [NREQ-1:0]   curOneHot;
    logic              arbGo;
    logic              tmoExpired;
    logic              gapDone;

    // Round-robin: first pass covers rrPtr..NREQ-1, second pass wraps to 0..rrPtr-1.
    always_comb begin
        pickValid = 1'b0;
        pickId    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!pickValid && bus.req[i] && (IdW'(i) >= rrPtrQ)) begin
                pickValid = 1'b1;
                pickId    = IdW'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!pickValid && bus.req[i]) begin
                pickValid = 1'b1;
                pickId    = IdW'(i);
            end
        end
    end

    always_comb begin
        pickOneHot = '0;
        curOneHot  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            pickOneHot[i] = (pickId == IdW'(i));
            curOneHot[i]  = (curIdQ == IdW'(i));
        end
    end

    assign arbGo      = pickValid && bus.link_ready;
    assign tmoExpired = (tmoCntQ == TmoW'(TIMEOUT - 1));
    assign gapDone    = (gapCntQ == GapW'(GAP - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: begin
                if (arbGo) stateD = StStart;
            end
            StStart: begin
                if (bus.link_busy)   stateD = StXfer;
                else if (tmoExpired) stateD = StGap;
            end
            StXfer: begin
                if (!bus.link_busy)  stateD = StGap;
                else if (tmoExpired) stateD = StGap;
            end
            StGap: begin
                if (gapDone) stateD = StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        rrPtrD     = rrPtrQ;
        tmoCntD    = tmoCntQ;
        gapCntD    = gapCntQ;
        linkStartD = linkStartQ;
        linkBufD   = linkBufQ;
        grantD     = grantQ;
        doneD      = '0;
        errD       = '0;
        curIdD     = curIdQ;
        unique case (stateQ)
            StIdle: begin
                if (arbGo) begin
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        if (pickId == IdW'(i)) linkBufD = bus.buf_in[i*WIDTH +: WIDTH];
                    end
                    grantD     = pickOneHot;
                    curIdD     = pickId;
                    rrPtrD     = (pickId == IdW'(NREQ - 1)) ? '0 : pickId + IdW'(1);
                    tmoCntD    = '0;
                    gapCntD    = '0;
                    linkStartD = 1'b1;
                end
            end
            StStart: begin
                if (bus.link_busy) begin
                    linkStartD = 1'b0;
                    tmoCntD    = '0;
                end else if (tmoExpired) begin
                    linkStartD = 1'b0;
                    errD       = curOneHot;
                end else begin
                    tmoCntD = tmoCntQ + TmoW'(1);
                end
            end
            StXfer: begin
                linkStartD = 1'b0;
                if (!bus.link_busy) begin
                    doneD = curOneHot;
                end else if (tmoExpired) begin
                    errD = curOneHot;
                end else begin
                    tmoCntD = tmoCntQ + TmoW'(1);
                end
            end
            StGap: begin
                grantD  = '0;
                gapCntD = gapDone ? '0 : gapCntQ + GapW'(1);
            end
            default: ;
        endcase
        busyD = (stateD != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrPtrQ     <= '0;
            tmoCntQ    <= '0;
            gapCntQ    <= '0;
            linkStartQ <= 1'b0;
            linkBufQ   <= '0;
            grantQ     <= '0;
            doneQ      <= '0;
            errQ       <= '0;
            busyQ      <= 1'b0;
            curIdQ     <= '0;
        end else begin
            rrPtrQ     <= rrPtrD;
            tmoCntQ    <= tmoCntD;
            gapCntQ    <= gapCntD;
            linkStartQ <= linkStartD;
            linkBufQ   <= linkBufD;
            grantQ     <= grantD;
            doneQ      <= doneD;
            errQ       <= errD;
            busyQ      <= busyD;
            curIdQ     <= curIdD;
        end
    end

    assign bus.link_start = linkStartQ;
    assign bus.link_buf   = linkBufQ;
    assign bus.grant      = grantQ;
    assign bus.done       = doneQ;
    assign bus.err        = errQ;
    assign bus.busy       = busyQ;
    assign bus.cur_id     = curIdQ;
endmodule

// File: tb/tb_comms_tx_scheduler.sv
// Scoreboard bench for comms_tx_scheduler (NREQ=4, WIDTH=256, GAP=16, TIMEOUT=4096).
// Stimulus pushes expected grant/done/err events; a negedge monitor pops and compares.
// A small serializer model drives link_busy (normal / stuck-low / stuck-high).
module tb_comms_tx_scheduler;
    localparam int NREQ = 4;
    localparam int WIDTH = 256;
    localparam int GAP = 16;
    localparam int TIMEOUT = 4096;

    localparam int KGrant = 0;
    localparam int KDone  = 1;
    localparam int KErr   = 2;

    typedef struct {
        int              kind;
        logic [3:0]      vec;
        logic [255:0]    data;
    } exp_t;

    logic clk;
    logic rst;
    comms_tx_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    comms_tx_scheduler #(
        .NREQ(NREQ), .WIDTH(WIDTH), .GAP(GAP), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t expQ[$];
    int   nCompared = 0;
    int   nMismatch = 0;
    int   doneCnt = 0;
    int   busyMode = 0;  // 0 normal, 1 stuck low, 2 stuck high once started
    int   riseDelay = 3;
    int   busyLen = 2048;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pushExp(input int k, input logic [3:0] v, input logic [255:0] d);
        exp_t e;
        e.kind = k;
        e.vec  = v;
        e.data = d;
        expQ.push_back(e);
    endtask

    function automatic int ohToId(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic popCheck(input int k, input logic [3:0] v, input logic [255:0] d,
                            input logic [1:0] id);
        exp_t e;
        if (expQ.size() == 0) begin
            nCompared++;
            nMismatch++;
            $display("FAIL unexpected_event: got kind %0d vec %b, expected none", k, v);
        end else begin
            e = expQ.pop_front();
            chk("event_kind", k, e.kind);
            chk("event_vec", v, e.vec);
            if (e.kind == KGrant) begin
                chk("grant_link_buf", d, e.data);
                chk("grant_cur_id", id, ohToId(e.vec));
            end
        end
    endtask

    // Serializer model
    initial begin : serModel
        int ph;
        int d;
        int l;
        ph = 0; d = 0; l = 0;
        bus.link_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.link_busy = 1'b0;
                ph = 0;
            end else if (busyMode == 1) begin
                bus.link_busy = 1'b0;
                ph = 0;
            end else if (busyMode == 2) begin
                if (bus.link_start) bus.link_busy = 1'b1;
                ph = 0;
            end else begin
                case (ph)
                    0: begin
                        bus.link_busy = 1'b0;
                        if (bus.link_start) begin ph = 1; d = 0; end
                    end
                    1: begin
                        d++;
                        if (d >= riseDelay) begin bus.link_busy = 1'b1; ph = 2; l = 0; end
                    end
                    default: begin
                        l++;
                        if (l >= busyLen) begin bus.link_busy = 1'b0; ph = 0; end
                    end
                endcase
            end
        end
    end

    // Monitor
    initial begin : monitor
        logic prevStart;
        prevStart = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevStart = 1'b0;
            end else begin
                if (bus.link_start && !prevStart)
                    popCheck(KGrant, bus.grant, bus.link_buf, bus.cur_id);
                if (bus.done != 4'b0) begin
                    popCheck(KDone, bus.done, '0, '0);
                    doneCnt++;
                end
                if (bus.err != 4'b0) popCheck(KErr, bus.err, '0, '0);
                if ((bus.done != 4'b0) || (bus.err != 4'b0))
                    chk("done_err_exclusive", bus.done & bus.err, 0);
                prevStart = bus.link_start;
            end
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic setBuf(input int i, input logic [255:0] v);
        bus.buf_in[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic waitGrantStart(input string name);
        int n;
        n = 0;
        while (!bus.link_start && n < 50) begin @(negedge clk); n++; end
        chk({name, "_start_seen"}, bus.link_start, 1'b1);
    endtask

    task automatic waitXfer(input string name);
        int n;
        n = 0;
        while (!(bus.link_busy && !bus.link_start) && n < 50) begin @(negedge clk); n++; end
        chk({name, "_xfer_seen"}, bus.link_busy && !bus.link_start, 1'b1);
    endtask

    task automatic waitDonePulse(input string name, input int budget);
        int n;
        n = 0;
        while (bus.done == 4'b0 && n < budget) begin @(negedge clk); n++; end
        chk({name, "_done_seen"}, bus.done != 4'b0, 1'b1);
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 200) begin @(negedge clk); n++; end
        chk({name, "_idle"}, bus.busy, 1'b0);
    endtask

    logic [255:0] b0, b0New, b1, b2, b3;

    initial begin : stim
        int n;
        int base;
        logic flag;
        b0    = {8{32'hA0A0_0000}};
        b0New = {8{32'h5555_1234}};
        b1    = {8{32'hB1B1_0001}};
        b2    = (256'h1 << 255) | 256'h1;
        b3    = {8{32'hD3D3_0003}};

        rst = 1'b1;
        bus.req = '0;
        bus.buf_in = '0;
        bus.link_ready = 1'b1;
        #12;
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_grant", bus.grant, 0);
        chk("reset_link_start", bus.link_start, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // 1: reset in the middle of XFER
        riseDelay = 2; busyLen = 50;
        setBuf(0, b0);
        pushExp(KGrant, 4'b0001, b0);
        bus.req = 4'b0001;
        waitXfer("t1");
        #2 rst = 1'b1;
        #1;
        chk("t1_rst_link_start", bus.link_start, 1'b0);
        chk("t1_rst_link_buf", bus.link_buf, 0);
        chk("t1_rst_grant", bus.grant, 0);
        chk("t1_rst_done", bus.done, 0);
        chk("t1_rst_err", bus.err, 0);
        chk("t1_rst_busy", bus.busy, 1'b0);
        chk("t1_rst_cur_id", bus.cur_id, 0);
        bus.req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        flag = 1'b0;
        repeat (20) begin @(negedge clk); if (bus.busy) flag = 1'b1; end
        chk("t1_busy_after_release", flag, 1'b0);

        // 2: single frame from requester 2
        riseDelay = 3; busyLen = 2048;
        setBuf(2, b2);
        pushExp(KGrant, 4'b0100, b2);
        pushExp(KDone, 4'b0100, '0);
        bus.req = 4'b0100;
        @(negedge clk);
        chk("t2_grant_latency", bus.grant, 4'b0100);
        chk("t2_link_start", bus.link_start, 1'b1);
        chk("t2_busy", bus.busy, 1'b1);
        waitDonePulse("t2", 2200);
        bus.req = '0;
        n = 0;
        while (bus.busy && n < 100) begin @(negedge clk); n++; end
        chk("t2_gap_cycles", n, GAP);
        chk("t2_grant_cleared", bus.grant, 0);
        chk("t2_link_buf_held", bus.link_buf, b2);

        // 3: round robin, starting after requester 2 -> 3,0,1,2,3
        riseDelay = 1; busyLen = 5;
        setBuf(0, b0); setBuf(1, b1); setBuf(3, b3);
        pushExp(KGrant, 4'b1000, b3); pushExp(KDone, 4'b1000, '0);
        pushExp(KGrant, 4'b0001, b0); pushExp(KDone, 4'b0001, '0);
        pushExp(KGrant, 4'b0010, b1); pushExp(KDone, 4'b0010, '0);
        pushExp(KGrant, 4'b0100, b2); pushExp(KDone, 4'b0100, '0);
        pushExp(KGrant, 4'b1000, b3); pushExp(KDone, 4'b1000, '0);
        base = doneCnt;
        bus.req = 4'b1111;
        n = 0;
        while (doneCnt < base + 5 && n < 600) begin @(negedge clk); n++; end
        bus.req = '0;
        chk("t3_frames_done", doneCnt - base, 5);
        waitIdle("t3");

        // 4a: link_busy stuck low -> START timeout
        busyMode = 1;
        pushExp(KGrant, 4'b0010, b1);
        pushExp(KErr, 4'b0010, '0);
        bus.req = 4'b0010;
        waitGrantStart("t4a");
        n = 0;
        while (bus.link_start && n < 5000) begin @(negedge clk); n++; end
        chk("t4a_start_len", n, TIMEOUT);
        chk("t4a_err_pulse", bus.err, 4'b0010);
        bus.req = '0;
        waitIdle("t4a");

        // 4b: link_busy stuck high -> XFER timeout
        busyMode = 2;
        pushExp(KGrant, 4'b0001, b0);
        pushExp(KErr, 4'b0001, '0);
        bus.req = 4'b0001;
        waitGrantStart("t4b");
        n = 0;
        while (bus.link_start && n < 50) begin @(negedge clk); n++; end
        n = 0;
        while (bus.err == 4'b0 && n < 5000) begin @(negedge clk); n++; end
        chk("t4b_xfer_len", n, TIMEOUT);
        busyMode = 0;
        bus.req = '0;
        waitIdle("t4b");

        // 5: flow control
        riseDelay = 2; busyLen = 20;
        bus.link_ready = 1'b0;
        bus.req = 4'b0001;
        flag = 1'b0;
        repeat (100) begin @(negedge clk); if (bus.busy || bus.grant != 4'b0) flag = 1'b1; end
        chk("t5_blocked", flag, 1'b0);
        pushExp(KGrant, 4'b0001, b0);
        pushExp(KDone, 4'b0001, '0);
        bus.link_ready = 1'b1;
        @(negedge clk);
        chk("t5_grant_latency", bus.grant, 4'b0001);

        // 6: buffer latched at grant; dropping req does not abort
        @(negedge clk);
        setBuf(0, b0New);
        waitXfer("t6");
        chk("t6_buf_during_xfer", bus.link_buf, b0);
        bus.req = '0;
        waitDonePulse("t6", 100);
        chk("t6_buf_at_done", bus.link_buf, b0);
        waitIdle("t6");
        chk("t6_buf_held_idle", bus.link_buf, b0);
        pushExp(KGrant, 4'b0001, b0New);
        pushExp(KDone, 4'b0001, '0);
        bus.req = 4'b0001;
        waitDonePulse("t6b", 100);
        bus.req = '0;
        waitIdle("t6b");
        repeat (2) @(negedge clk);

        chk("scoreboard_drained", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end
endmodule
